blake2_host_drv: RTL

- Host-side driver for the BLAKE2s pin protocol. It generates `valid`/`cmd`/`data` on the ASIC input pins and collects the digest from the `hash_finished`/`hash` output pins.
- Lives in the FPGA test harness and the system bench. It connects directly to the chip's `uio`/`ui`/`uo` pins.
- It accepts a job (`kk`, `nn`, `ll`) and a byte stream (key bytes, then message bytes) from a local source, then returns digest bytes as a stream.

---
 rtl/blake2_pkg.sv | 37 +++
 rtl/blake2_host_blk_seq.sv | 58 +++++
 rtl/blake2_host_drv.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/blake2_pkg.sv
// Shared constants, command encodings and FSM state type for the BLAKE2s host driver.
package blake2_pkg;

    localparam logic [1:0] CMD_CONF = 2'd0;
    localparam logic [1:0] CMD_DATA = 2'd2;

    localparam int unsigned BLOCK_BYTES = 64;
    localparam int unsigned CONF_BYTES  = 10;
    localparam int unsigned MAX_NN      = 32;
    localparam int unsigned MAX_KK      = 32;

    typedef enum logic [2:0] {
        StIdle,
        StConf,
        StKey,
        StData,
        StGap,
        StWait,
        StRead,
        StDone
    } blake2_state_e;

    // CONF beat idx: kk, nn, then the message length little-endian.
    function automatic logic [7:0] conf_byte(input logic [6:0]  kk,
                                             input logic [6:0]  nn,
                                             input logic [63:0] ll,
                                             input logic [3:0]  idx);
        logic [63:0] sh;
        sh = ll >> {idx - 4'd2, 3'b000};
        case (idx)
            4'd0:    return {1'b0, kk};
            4'd1:    return {1'b0, nn};
            default: return sh[7:0];
        endcase
    endfunction

endpackage

// File: rtl/blake2_host_blk_seq.sv
// 64-beat block sequencer: fetches bytes from the source while the remaining count is
// non-zero, then zero-pads the rest of the block.
module blake2_host_blk_seq
    import blake2_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        load_i,
    input  logic [63:0] load_len_i,
    input  logic        active_i,
    input  logic        msg_v_i,
    input  logic [7:0]  msg_i,
    output logic        msg_ready_o,
    output logic        valid_o,
    output logic [7:0]  data_o,
    output logic        blk_done_o,
    output logic        len_done_o
);

    logic [63:0] rem_d, rem_q;
    logic [6:0]  beat_d, beat_q;
    logic        need, take;

    always_comb begin
        need        = (rem_q != 64'd0);
        msg_ready_o = active_i & need;
        // Padding beats never stall; source beats wait for msg_v_i.
        valid_o     = active_i & (~need | msg_v_i);
        take        = msg_ready_o & msg_v_i;
        data_o      = take ? msg_i : 8'h00;
        blk_done_o  = valid_o & (beat_q == 7'(BLOCK_BYTES - 1));
        len_done_o  = ~need | (take & (rem_q == 64'd1));

        rem_d  = rem_q;
        beat_d = beat_q;
        if (take) begin
            rem_d = rem_q - 64'd1;
        end
        if (valid_o) begin
            beat_d = blk_done_o ? 7'd0 : beat_q + 7'd1;
        end
        if (load_i) begin
            rem_d  = load_len_i;
            beat_d = 7'd0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rem_q  <= 64'd0;
            beat_q <= 7'd0;
        end else begin
            rem_q  <= rem_d;
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/blake2_host_drv.sv
// Host-side BLAKE2s pin-protocol driver: CONF, KEY/DATA blocks, inter-block gap, digest read.
// Optional WAIT timeout with err_o is enabled by defining BLAKE2_HOST_TIMEOUT_EN.
module blake2_host_drv
    import blake2_pkg::*;
#(
    parameter int unsigned BLOCK_GAP = 24,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start_i,
    input  logic [6:0]  kk_i,
    input  logic [6:0]  nn_i,
    input  logic [63:0] ll_i,
    output logic        busy_o,
    input  logic        msg_v_i,
    input  logic [7:0]  msg_i,
    output logic        msg_ready_o,
    output logic        hash_v_o,
    output logic [7:0]  hash_o,
    output logic        hash_last_o,
    output logic        err_o,
    output logic        valid_o,
    output logic [1:0]  cmd_o,
    output logic [7:0]  data_o,
    input  logic        hash_finished_i,
    input  logic [7:0]  hash_i
);

    localparam logic [15:0] GapLast    = 16'(BLOCK_GAP - 1);
    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

    blake2_state_e state_d, state_q;
    logic [6:0]    kk_d, kk_q, nn_d, nn_q, cnt_d, cnt_q, kk_c, nn_c, rd_next;
    logic [63:0]   ll_d, ll_q, seq_len;
    logic [15:0]   gap_d, gap_q;
    logic [7:0]    hb_d, hb_q, seq_data;
    logic          hv_d, hv_q, last_d, last_q;
    logic          seq_load, seq_active, seq_valid, seq_blk_done, seq_len_done;
    logic          last_blk, cap;
`ifdef BLAKE2_HOST_TIMEOUT_EN
    logic          err_d, err_q;
`endif

    blake2_host_blk_seq u_blk_seq (
        .clk         (clk),
        .nreset      (nreset),
        .load_i      (seq_load),
        .load_len_i  (seq_len),
        .active_i    (seq_active),
        .msg_v_i     (msg_v_i),
        .msg_i       (msg_i),
        .msg_ready_o (msg_ready_o),
        .valid_o     (seq_valid),
        .data_o      (seq_data),
        .blk_done_o  (seq_blk_done),
        .len_done_o  (seq_len_done)
    );

    always_comb begin
        state_d    = state_q;
        kk_d       = kk_q;
        nn_d       = nn_q;
        ll_d       = ll_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        hv_d       = 1'b0;
        hb_d       = 8'h00;
        last_d     = 1'b0;
        seq_load   = 1'b0;
        seq_len    = ll_q;
        seq_active = 1'b0;
        valid_o    = 1'b0;
        cmd_o      = 2'd0;
        data_o     = 8'h00;
        last_blk   = 1'b0;
        cap        = 1'b0;
        rd_next    = cnt_q + 7'd1;
`ifdef BLAKE2_HOST_TIMEOUT_EN
        err_d      = err_q;
`endif
        kk_c = (kk_i > 7'(MAX_KK)) ? 7'(MAX_KK) : kk_i;
        nn_c = (nn_i == 7'd0) ? 7'd1 : ((nn_i > 7'(MAX_NN)) ? 7'(MAX_NN) : nn_i);

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    kk_d     = kk_c;
                    nn_d     = nn_c;
                    ll_d     = ll_i;
                    cnt_d    = 7'd0;
                    seq_load = 1'b1;
                    seq_len  = (kk_c != 7'd0) ? {57'd0, kk_c} : ll_i;
                    state_d  = StConf;
`ifdef BLAKE2_HOST_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                end
            end
            StConf: begin
                valid_o = 1'b1;
                cmd_o   = CMD_CONF;
                data_o  = conf_byte(kk_q, nn_q, ll_q, cnt_q[3:0]);
                if (cnt_q == 7'(CONF_BYTES - 1)) begin
                    cnt_d   = 7'd0;
                    state_d = (kk_q != 7'd0) ? StKey : StData;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            StKey, StData: begin
                seq_active = 1'b1;
                valid_o    = seq_valid;
                cmd_o      = seq_valid ? CMD_DATA : 2'd0;
                data_o     = seq_data;
                if (seq_blk_done) begin
                    // The key block hands the sequencer over to the message length.
                    if (state_q == StKey) begin
                        seq_load = 1'b1;
                        last_blk = (ll_q == 64'd0);
                    end else begin
                        last_blk = seq_len_done;
                    end
                    state_d = last_blk ? StWait : StGap;
                    gap_d   = last_blk ? 16'd1 : 16'd0;
                end
            end
            StGap: begin
                gap_d = gap_q + 16'd1;
                if (gap_q == GapLast) begin
                    gap_d   = 16'd0;
                    state_d = StData;
                end
            end
            StWait: begin
                if (gap_q != TimeoutCnt) begin
                    gap_d = gap_q + 16'd1;
                end
                cap = hash_finished_i;
`ifdef BLAKE2_HOST_TIMEOUT_EN
                if (!hash_finished_i && gap_q == TimeoutCnt - 16'd1) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
`endif
            end
            StRead: begin
                cap = hash_finished_i;
                if (!hash_finished_i) begin
                    state_d = StIdle;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (cap) begin
            hv_d    = 1'b1;
            hb_d    = hash_i;
            cnt_d   = rd_next;
            last_d  = (rd_next == nn_q);
            state_d = last_d ? StDone : StRead;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= StIdle;
            kk_q    <= 7'd0;
            nn_q    <= 7'd0;
            ll_q    <= 64'd0;
            cnt_q   <= 7'd0;
            gap_q   <= 16'd0;
            hv_q    <= 1'b0;
            hb_q    <= 8'h00;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kk_q    <= kk_d;
            nn_q    <= nn_d;
            ll_q    <= ll_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            hv_q    <= hv_d;
            hb_q    <= hb_d;
            last_q  <= last_d;
        end
    end

`ifdef BLAKE2_HOST_TIMEOUT_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign busy_o   = (state_q != StIdle);
    assign hash_v_o = hv_q;
    assign hash_o   = hb_q;
    // An early drop of hash_finished_i makes the byte already on hash_o the last one.
    assign hash_last_o = hv_q & (last_q | ((state_q == StRead) & ~hash_finished_i));

endmodule
